start_sequencer: RTL and testbench
==================================

Name: start_sequencer

Overview:
- Controller that sequences a three-phase READY -> SET -> GO start signal on behalf of a requester.
- Each phase is held for a parameterised dwell time, measured in cycles.
- Uses a request/acknowledge handshake and supports abort.
- Every encoded state is reachable and has a defined exit, so the block serves as the clean FSM counterpart in the fsm lint set.

Parameters:
- READY_CYCLES, 4, dwell in READY in cycles; a value of 0 is treated as 1.
- SET_CYCLES, 3, dwell in SET in cycles; a value of 0 is treated as 1.
- GO_CYCLES, 2, dwell in GO in cycles; a value of 0 is treated as 1.
- CNT_W, 8, dwell counter width; every dwell value must fit in CNT_W bits.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start_req  input  1  request to begin a sequence; level, sampled each posedge.
- abort  input  1  cancel an in-progress sequence.
- start_ack  output  1  one-cycle pulse: request accepted.
- state  output  2  current state: IDLE=2'b00, READY=2'b01, SET=2'b10, GO=2'b11.
- ready_o  output  1  high while state==READY.
- set_o  output  1  high while state==SET.
- go_o  output  1  high while state==GO.
- busy  output  1  high while state!=IDLE.
- done  output  1  one-cycle pulse on normal completion (GO -> IDLE).

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, counter=0, all outputs 0.
- Reset mid-sequence forces IDLE on the next edge; no done pulse.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- Two-process FSM: a state register plus a combinational next-state block. The next-state block has a default assignment, so there are no latches.
- IDLE:
  - If start_req=1 and abort=0 at an edge, go to READY, load counter=0, and assert start_ack for exactly the following cycle.
  - Otherwise stay in IDLE.
- READY:
  - The counter increments each cycle.
  - When counter == max(READY_CYCLES,1)-1, go to SET and clear the counter.
  - READY therefore lasts exactly READY_CYCLES cycles.
- SET: same rule using SET_CYCLES; exits to GO.
- GO:
  - Same rule using GO_CYCLES; exits to IDLE.
  - Assert done for the single cycle in which state first shows IDLE.
- abort=1 in READY, SET or GO: the next state is IDLE, the counter is cleared, and no done pulse is issued.
- abort=1 in IDLE: no effect, but it blocks acceptance of start_req that cycle (abort wins).
- start_req while busy: ignored, no start_ack. A held start_req is accepted again in the first IDLE cycle after completion.
  - Consequence: the earliest restart is the cycle after done; back-to-back sequences have a one-cycle IDLE gap.
- Total busy duration for a sequence with no abort: READY_CYCLES + SET_CYCLES + GO_CYCLES cycles. With defaults this is 9 cycles.
- The counter never wraps: it is cleared on every state change and compared with ==.
- ready_o, set_o and go_o are one-hot while busy and all zero in IDLE.

Optional Feature:
- Macro: START_SEQUENCER_FALSE_START_EN.
- When defined:
  - Adds input false_start (1 bit) and outputs fault (1 bit, pulse) and fault_flag (1 bit, sticky).
  - false_start=1 in READY or SET sends the FSM to IDLE next edge, with no done.
  - fault pulses for one cycle.
  - fault_flag is set and stays set until the next accepted start (cleared in the same cycle start_ack asserts) or until rst.
  - false_start in GO or IDLE is ignored.
  - If abort and false_start are both high, abort wins and fault is not raised.
- When undefined: these ports do not exist and the behaviour is exactly as above.

Test Plan:
- Reset then a single start (defaults): rst high 2 cycles, then start_req for 1 cycle. Required:
  - start_ack high 1 cycle.
  - ready_o high 4 cycles, then set_o 3 cycles, then go_o 2 cycles.
  - done pulses 1 cycle; busy is high for exactly 9 cycles.
- Abort in SET: start, then abort pulsed on the 2nd SET cycle. Required: state=IDLE next cycle, done never asserts, busy is high for 6 cycles total.
- Held start_req: start_req held high for 25 cycles. Required: sequences run back-to-back, each done followed by start_ack in the next cycle, 2 complete sequences within the window, start_ack count = done count + (1 if a sequence is still in progress).
- Simultaneous start_req=1 and abort=1 in IDLE: no start_ack, state stays 2'b00. start_req alone on the next cycle is accepted.
- Reset mid-GO: assert rst on the 1st GO cycle. Required: all outputs 0 next cycle, no done. Parameter override READY_CYCLES=0 gives a READY dwell of 1 cycle.
- With START_SEQUENCER_FALSE_START_EN: false_start on the 3rd READY cycle. Required: IDLE next cycle, fault pulses once, fault_flag=1 until the next start_ack. false_start during GO has no effect.

Source files
------------

// File: rtl/start_sequencer_if.sv
// Handshake and status bundle between a requester and start_sequencer.
// START_SEQUENCER_FALSE_START_EN adds false_start, fault and fault_flag.
interface start_sequencer_if;
  logic       start_req;
  logic       abort;
  logic       start_ack;
  logic [1:0] state;
  logic       ready_o;
  logic       set_o;
  logic       go_o;
  logic       busy;
  logic       done;
`ifdef START_SEQUENCER_FALSE_START_EN
  logic       false_start;
  logic       fault;
  logic       fault_flag;
`endif

  modport master (
    output start_req,
    output abort,
`ifdef START_SEQUENCER_FALSE_START_EN
    output false_start,
    input  fault,
    input  fault_flag,
`endif
    input  start_ack,
    input  state,
    input  ready_o,
    input  set_o,
    input  go_o,
    input  busy,
    input  done
  );

  modport slave (
    input  start_req,
    input  abort,
`ifdef START_SEQUENCER_FALSE_START_EN
    input  false_start,
    output fault,
    output fault_flag,
`endif
    output start_ack,
    output state,
    output ready_o,
    output set_o,
    output go_o,
    output busy,
    output done
  );
endinterface

// File: rtl/start_sequencer.sv
// READY -> SET -> GO start sequencer with per-phase dwell, req/ack handshake and abort.
// Optional false-start detection is enabled by defining START_SEQUENCER_FALSE_START_EN.
module start_sequencer #(
  parameter int unsigned READY_CYCLES = 4,
  parameter int unsigned SET_CYCLES   = 3,
  parameter int unsigned GO_CYCLES    = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  start_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReady = 2'b01,
    StSet   = 2'b10,
    StGo    = 2'b11
  } state_e;

  // Last counter value of each phase; a zero dwell behaves as a one-cycle dwell.
  localparam logic [CNT_W-1:0] ReadyLast = CNT_W'((READY_CYCLES == 0) ? 0 : READY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SetLast   = CNT_W'((SET_CYCLES == 0) ? 0 : SET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GoLast    = CNT_W'((GO_CYCLES == 0) ? 0 : GO_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             ready_q, set_q, go_q, busy_q;
`ifdef START_SEQUENCER_FALSE_START_EN
  logic             fault_q, fault_d;
  logic             flag_q, flag_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
`ifdef START_SEQUENCER_FALSE_START_EN
    fault_d = 1'b0;
    flag_d  = flag_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start_req && !bus.abort) begin
          state_d = StReady;
          cnt_d   = '0;
          ack_d   = 1'b1;
`ifdef START_SEQUENCER_FALSE_START_EN
          flag_d  = 1'b0;
`endif
        end
      end
      StReady: begin
        if (cnt_q == ReadyLast) begin
          state_d = StSet;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StSet: begin
        if (cnt_q == SetLast) begin
          state_d = StGo;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGo: begin
        if (cnt_q == GoLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides both normal completion and a simultaneous false start.
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
`ifdef START_SEQUENCER_FALSE_START_EN
    else if (bus.false_start && ((state_q == StReady) || (state_q == StSet))) begin
      state_d = StIdle;
      cnt_d   = '0;
      fault_d = 1'b1;
      flag_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      set_q   <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef START_SEQUENCER_FALSE_START_EN
      fault_q <= 1'b0;
      flag_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      ready_q <= (state_d == StReady);
      set_q   <= (state_d == StSet);
      go_q    <= (state_d == StGo);
      busy_q  <= (state_d != StIdle);
`ifdef START_SEQUENCER_FALSE_START_EN
      fault_q <= fault_d;
      flag_q  <= flag_d;
`endif
    end
  end

  assign bus.state     = state_q;
  assign bus.start_ack = ack_q;
  assign bus.done      = done_q;
  assign bus.ready_o   = ready_q;
  assign bus.set_o     = set_q;
  assign bus.go_o      = go_q;
  assign bus.busy      = busy_q;
`ifdef START_SEQUENCER_FALSE_START_EN
  assign bus.fault      = fault_q;
  assign bus.fault_flag = flag_q;
`endif

endmodule

// File: tb/tb_start_sequencer.sv
// Bench for start_sequencer: directed scenarios plus random traffic against a timeline model.
// Runs two instances: default dwells and READY_CYCLES=0.
module tb_start_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rq  = 1'b0;
  logic ab  = 1'b0;
  logic fs  = 1'b0;

  always #5 clk = ~clk;

  start_sequencer_if if0 ();
  start_sequencer_if if1 ();

  assign if0.start_req = rq;
  assign if0.abort     = ab;
  assign if1.start_req = rq;
  assign if1.abort     = ab;
`ifdef START_SEQUENCER_FALSE_START_EN
  assign if0.false_start = fs;
  assign if1.false_start = fs;
`endif

  start_sequencer u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  start_sequencer #(
    .READY_CYCLES (0)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // A sequence is a timeline: elapsed cycles since acceptance select the phase.
  typedef struct {
    bit active;
    int el;
    bit ack;
    bit done;
    bit fault;
    bit flag;
  } model_t;

  localparam int R0 = 4, S0 = 3, G0 = 2;
  localparam int R1 = 1, S1 = 3, G1 = 2;

  model_t m0, m1;
  int errors = 0;
  int checks = 0;
  int n_busy, n_ready, n_set, n_go, n_ack, n_done, n_fault, n_busy1, n_ready1;

  function automatic model_t step(model_t m, bit r_req, bit r_ab, bit r_fs, bit r_rst,
                                  int r, int s, int g);
    model_t n;
    bit     fs_used;
    n = m;
    n.ack   = 1'b0;
    n.done  = 1'b0;
    n.fault = 1'b0;
`ifdef START_SEQUENCER_FALSE_START_EN
    fs_used = r_fs;
`else
    fs_used = 1'b0;
`endif
    if (r_rst) begin
      n = '{default: 0};
    end else if (!m.active) begin
      if (r_req && !r_ab) begin
        n.active = 1'b1;
        n.el     = 0;
        n.ack    = 1'b1;
        n.flag   = 1'b0;
      end
    end else if (r_ab) begin
      n.active = 1'b0;
    end else if (fs_used && (m.el < r + s)) begin
      n.active = 1'b0;
      n.fault  = 1'b1;
      n.flag   = 1'b1;
    end else if (m.el + 1 == r + s + g) begin
      n.active = 1'b0;
      n.done   = 1'b1;
    end else begin
      n.el = m.el + 1;
    end
    return n;
  endfunction

  function automatic logic [9:0] expv(model_t m, int r, int s);
    logic [1:0] st;
    if (!m.active)         st = 2'b00;
    else if (m.el < r)     st = 2'b01;
    else if (m.el < r + s) st = 2'b10;
    else                   st = 2'b11;
    return {st, st == 2'b01, st == 2'b10, st == 2'b11, m.active, m.ack, m.done,
            m.fault, m.flag};
  endfunction

  function automatic logic [9:0] actv0();
    logic f, ff;
`ifdef START_SEQUENCER_FALSE_START_EN
    f = if0.fault; ff = if0.fault_flag;
`else
    f = 1'b0; ff = 1'b0;
`endif
    return {if0.state, if0.ready_o, if0.set_o, if0.go_o, if0.busy, if0.start_ack, if0.done,
            f, ff};
  endfunction

  function automatic logic [9:0] actv1();
    logic f, ff;
`ifdef START_SEQUENCER_FALSE_START_EN
    f = if1.fault; ff = if1.fault_flag;
`else
    f = 1'b0; ff = 1'b0;
`endif
    return {if1.state, if1.ready_o, if1.set_o, if1.go_o, if1.busy, if1.start_ack, if1.done,
            f, ff};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic clr();
    n_busy = 0; n_ready = 0; n_set = 0; n_go = 0; n_ack = 0; n_done = 0; n_fault = 0;
    n_busy1 = 0; n_ready1 = 0;
  endtask

  // Called at a negedge: apply inputs for one clock, update models, compare at the next negedge.
  task automatic cycle(bit c_rq, bit c_ab, bit c_fs, bit c_rst);
    rq = c_rq; ab = c_ab; fs = c_fs; rst = c_rst;
    @(posedge clk);
    m0 = step(m0, c_rq, c_ab, c_fs, c_rst, R0, S0, G0);
    m1 = step(m1, c_rq, c_ab, c_fs, c_rst, R1, S1, G1);
    @(negedge clk);
    chk("outputs_dut0", 32'(actv0()), 32'(expv(m0, R0, S0)));
    chk("outputs_dut1", 32'(actv1()), 32'(expv(m1, R1, S1)));
    n_busy  += int'(if0.busy);
    n_ready += int'(if0.ready_o);
    n_set   += int'(if0.set_o);
    n_go    += int'(if0.go_o);
    n_ack   += int'(if0.start_ack);
    n_done  += int'(if0.done);
    n_busy1  += int'(if1.busy);
    n_ready1 += int'(if1.ready_o);
`ifdef START_SEQUENCER_FALSE_START_EN
    n_fault += int'(if0.fault);
`endif
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    clr();
    @(negedge clk);

    // Reset then a single start
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_state", 32'(if0.state), 32'd0);
    chk("reset_busy", 32'(if0.busy), 32'd0);
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("first_ack", 32'(if0.start_ack), 32'd1);
    chk("first_ready", 32'(if0.ready_o), 32'd1);
    idle(12);
    chk("single_ack_cnt", n_ack, 1);
    chk("single_ready_cnt", n_ready, 4);
    chk("single_set_cnt", n_set, 3);
    chk("single_go_cnt", n_go, 2);
    chk("single_done_cnt", n_done, 1);
    chk("single_busy_cnt", n_busy, 9);
    chk("r0_ready_cnt", n_ready1, 1);
    chk("r0_busy_cnt", n_busy1, 6);

    // Abort on the second SET cycle
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("abort_in_set1", 32'(if0.set_o), 32'd1);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort_state", 32'(if0.state), 32'd0);
    idle(10);
    chk("abort_busy_cnt", n_busy, 6);
    chk("abort_done_cnt", n_done, 0);

    // Held start_req for 25 cycles
    clr();
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("held_done_cnt", n_done, 2);
    chk("held_ack_cnt", n_ack, 3);
    chk("held_busy_now", 32'(if0.busy), 32'd1);
    idle(12);

    // start_req with abort in IDLE
    clr();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("req_abort_ack", 32'(if0.start_ack), 32'd0);
    chk("req_abort_state", 32'(if0.state), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("req_after_ack", 32'(if0.start_ack), 32'd1);
    idle(12);

    // Reset on the first GO cycle
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    chk("go_before_rst", 32'(if0.go_o), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_go_outputs", 32'(actv0()), 32'd0);
    idle(3);
    chk("rst_go_done_cnt", n_done, 0);

`ifdef START_SEQUENCER_FALSE_START_EN
    // False start on the third READY cycle, then false start during GO
    clr();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fs_state", 32'(if0.state), 32'd0);
    chk("fs_fault", 32'(if0.fault), 32'd1);
    idle(3);
    chk("fs_flag_held", 32'(if0.fault_flag), 32'd1);
    chk("fs_fault_cnt", n_fault, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fs_flag_cleared", 32'(if0.fault_flag), 32'd0);
    idle(7);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fs_in_go_ignored", 32'(if0.go_o), 32'd1);
    idle(4);
    chk("fs_go_done_cnt", n_done, 1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
